// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns pc, reads line_mem, hands lines to decode over valid/ready.
// Latency: a line read at pc is visible on instr one cycle later; one instruction per cycle with ready high.
// Backpressure: instr_valid && !instr_ready stalls fetch (mem_en=0) and holds instr/instr_ip/pc stable.
module fetch_unit #(
  parameter int                    IP_WIDTH   = 8,
  parameter int                    LINE_WIDTH = 32,
  parameter int                    NUM_LINES  = 4,
  parameter logic [LINE_WIDTH-1:0] HALT_WORD  = {LINE_WIDTH{1'b1}},
  parameter logic [IP_WIDTH-1:0]   RESET_IP   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic [IP_WIDTH-1:0]   mem_ip,
  input  logic [LINE_WIDTH-1:0] mem_line,
  output logic [LINE_WIDTH-1:0] instr,
  output logic [IP_WIDTH-1:0]   instr_ip,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [IP_WIDTH-1:0]   redirect_ip,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Highest legal fetch address; the halt-sentinel slot itself is fetchable.
  localparam logic [IP_WIDTH-1:0] LAST_IP = IP_WIDTH'(NUM_LINES);

  state_t                state_q, state_d;
  logic [IP_WIDTH-1:0]   pc_q, pc_d;
  logic [LINE_WIDTH-1:0] instr_q, instr_d;
  logic [IP_WIDTH-1:0]   instr_ip_q, instr_ip_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic                  load;

  // A fetch happens only when running, not being redirected, and the IR is free or draining.
  always_comb begin
    load = (state_q == RUN) && !redirect_valid && (!instr_valid_q || instr_ready);
  end

  // Next-state logic: redirect beats fault beats halt beats a normal issue.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_ip_d    = instr_ip_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_IP;
        end
      end
      RUN: begin
        if (instr_valid_q && instr_ready) instr_valid_d = 1'b0;
        if (redirect_valid) begin
          // Flush the IR even when decode is stalled; the old path is dead.
          pc_d          = redirect_ip;
          instr_valid_d = 1'b0;
        end else if (load) begin
          if (pc_q > LAST_IP) begin
            // pc is left pointing at the offending address for debug.
            state_d       = FAULT;
            fault_d       = 1'b1;
            instr_valid_d = 1'b0;
          end else if (mem_line == HALT_WORD) begin
            // The sentinel is swallowed here and never reaches decode.
            state_d       = HALT;
            halted_d      = 1'b1;
            instr_valid_d = 1'b0;
          end else begin
            instr_d       = mem_line;
            instr_ip_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + IP_WIDTH'(1);
          end
        end
      end
      HALT: begin
        if (instr_valid_q && instr_ready) instr_valid_d = 1'b0;
      end
      FAULT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_IP;
      instr_q       <= '0;
      instr_ip_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_ip_q    <= instr_ip_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  // Outputs; mem_en is gated by rst so the read enable drops the moment reset asserts.
  always_comb begin
    mem_en      = load && !rst;
    mem_ip      = pc_q;
    instr       = instr_q;
    instr_ip    = instr_ip_q;
    instr_valid = instr_valid_q;
    halted      = halted_q;
    fault       = fault_q;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of line_mem. Owns the instruction pointer and drives line_mem's en/ip.
- Captures the returned line into an instruction register. Hands it to decode over a valid/ready handshake.
- Handles control-flow redirects. Stops on the halt sentinel word or on an out-of-range fetch.

Parameters:
- IP_WIDTH, 8, width of instruction pointer.
- LINE_WIDTH, 32, width of instruction line.
- NUM_LINES, 4, index of halt-sentinel slot; legal fetch range is 0..NUM_LINES.
- HALT_WORD, 32'hFFFFFFFF, sentinel line value that stops fetch.
- RESET_IP, 0, pointer loaded on start.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from RESET_IP; honoured only in IDLE
- mem_en  out  1  read enable to line_mem
- mem_ip  out  IP_WIDTH  fetch address to line_mem; always equals pc
- mem_line  in  LINE_WIDTH  line returned by line_mem, same cycle as mem_ip
- instr  out  LINE_WIDTH  instruction register contents
- instr_ip  out  IP_WIDTH  address instr was fetched from
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  decode accepts instr this cycle
- redirect_valid  in  1  jump/branch taken
- redirect_ip  in  IP_WIDTH  jump target
- halted  out  1  sticky; HALT_WORD was fetched
- fault  out  1  sticky; fetch attempted with pc > NUM_LINES

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_IP.
  - instr=0, instr_ip=0, instr_valid=0, halted=0, fault=0.
  - mem_en=0 combinationally while rst is high.
- States: IDLE, RUN, HALT, FAULT.
  - IDLE: start=1 -> RUN, pc<=RESET_IP. All other inputs ignored.
  - RUN: normal fetch, rules below.
  - HALT: terminal until rst. halted=1, mem_en=0. A pending instr_valid clears when instr_ready=1. Redirect and start ignored.
  - FAULT: terminal until rst. fault=1, mem_en=0, instr_valid forced 0 on entry. Redirect and start ignored.
- Fetch condition, combinational:
  - load = (state==RUN) && !redirect_valid && (!instr_valid || instr_ready).
  - mem_en = load.
  - mem_ip = pc at all times.
- RUN priority each rising edge, highest first:
  1. redirect_valid=1:
     - pc<=redirect_ip, instr_valid<=0. The IR is flushed even if instr_ready=0.
     - No fetch this cycle.
  2. load && pc > NUM_LINES:
     - -> FAULT, instr_valid<=0. pc is held for debug.
  3. load && mem_line==HALT_WORD:
     - -> HALT, halted<=1, instr_valid<=0, pc held.
     - The sentinel is never presented to decode.
  4. load, otherwise:
     - instr<=mem_line, instr_ip<=pc, instr_valid<=1.
     - pc<=pc+1, modulo 2^IP_WIDTH.
  5. !load (stall: instr_valid=1, instr_ready=0): pc, instr, instr_ip and instr_valid all held stable.
- Handshake:
  - A transfer occurs on an edge where instr_valid && instr_ready.
  - instr/instr_ip must not change while instr_valid=1 and instr_ready=0, except on flush.
- Latency and throughput:
  - start sampled at edge N puts the FSM in RUN. The first instr_valid=1 appears after edge N+1.
  - With instr_ready held high, one instruction is delivered per cycle.
- Boundaries:
  - pc==NUM_LINES is a legal fetch. It normally returns HALT_WORD and halts.
  - If the line at pc==NUM_LINES is not HALT_WORD, it issues normally; the next fetch at NUM_LINES+1 faults.
  - redirect_ip > NUM_LINES is accepted into pc. The fault is raised on the following fetch attempt.
  - Redirect in the same cycle as HALT_WORD on mem_line: the redirect wins and no halt occurs (load=0).
  - start while in RUN/HALT/FAULT is ignored.

Test Plan:
- Straight-line: line_mem lines 0..3 = 11111111,22222222,33333333,44444444, line 4 = FFFFFFFF; instr_ready=1; pulse start -> instr/instr_ip = 11111111@0, 22222222@1, 33333333@2, 44444444@3 on four consecutive cycles. Then halted=1 one cycle after the last transfer, instr_valid=0, mem_en=0 thereafter.
- Backpressure: instr_ready=0 for 3 cycles while instr=22222222@1 -> instr, instr_ip and instr_valid are unchanged, mem_en=0, mem_ip=2. Raise instr_ready -> next instr=33333333@2.
- Redirect during stall: instr=11111111@0 valid, instr_ready=0, redirect_valid=1 redirect_ip=3 for one cycle -> instr_valid=0 next cycle, mem_ip=3. The next delivered instr is 44444444@3, then halt.
- Fault: redirect_ip=6 with NUM_LINES=4 -> the next load cycle sets fault=1 and instr_valid stays 0. The block stays in FAULT; start and redirect are ignored.
- Redirect beats halt: pc=4 (mem_line=FFFFFFFF) with redirect_valid=1 redirect_ip=0 in the same cycle -> halted stays 0 and the next delivered instr is 11111111@0.
- Async reset: assert rst mid-run between clock edges -> instr_valid, mem_en, halted and fault go 0 immediately, and mem_ip=0. After release, no fetch occurs until start.
